// File: rtl/fib_regfile_checker_if.sv
// Control/status and regfile read port of the Fibonacci register-file checker.
// The checker takes the slave view; the test top level takes the master view.
interface fib_regfile_checker_if #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 16
);
    localparam int AW = $clog2(NUM_REGS);

    logic              start;
    logic [WIDTH-1:0]  rd_data;
    logic [AW-1:0]     rd_addr;
    logic              busy;
    logic              done;
    logic              pass;
    logic [AW-1:0]     fail_idx;
    logic [AW:0]       err_count;

    modport master (
        output start, rd_data,
        input  rd_addr, busy, done, pass, fail_idx, err_count
    );

    modport slave (
        input  start, rd_data,
        output rd_addr, busy, done, pass, fail_idx, err_count
    );
endinterface

// File: rtl/fib_regfile_checker.sv
// Reads the register file back one entry per clock and checks that each entry
// is the sum of the previous two, reporting pass, first failing index and count.
module fib_regfile_checker #(
    parameter int WIDTH       = 16,
    parameter int NUM_REGS    = 16,
    parameter int CHECK_SEEDS = 1,
    parameter int SEED0       = 1,
    parameter int SEED1       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    fib_regfile_checker_if.slave  bus
);
    localparam int AW    = $clog2(NUM_REGS);
    localparam int ERR_W = AW + 1;

    localparam logic [WIDTH-1:0] SEED0_V  = WIDTH'(SEED0);
    localparam logic [WIDTH-1:0] SEED1_V  = WIDTH'(SEED1);
    localparam logic [AW-1:0]    LAST_IDX = AW'(NUM_REGS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_next;
    logic [AW-1:0]     rd_addr, rd_addr_next;
    logic              busy, busy_next;
    logic              done, done_next;
    logic              pass, pass_next;
    logic [AW-1:0]     fail_idx, fail_idx_next;
    logic [ERR_W-1:0]  err_count, err_count_next;
    logic              fail_seen, fail_seen_next;
    logic [WIDTH-1:0]  prev1, prev1_next;
    logic [WIDTH-1:0]  prev2, prev2_next;
    logic              mismatch;

    assign bus.rd_addr   = rd_addr;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;
    assign bus.fail_idx  = fail_idx;
    assign bus.err_count = err_count;

    // History holds what was actually read, so one bad entry also poisons the next two checks.
    always_comb begin
        mismatch = 1'b0;
        if (state == RUN) begin
            if (rd_addr < AW'(2)) begin
                if (CHECK_SEEDS != 0)
                    mismatch = (bus.rd_data != ((rd_addr == '0) ? SEED0_V : SEED1_V));
            end else begin
                mismatch = (bus.rd_data != WIDTH'(prev2 + prev1));
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next     = state;
        rd_addr_next   = rd_addr;
        busy_next      = busy;
        done_next      = 1'b0;
        pass_next      = pass;
        fail_idx_next  = fail_idx;
        err_count_next = err_count;
        fail_seen_next = fail_seen;
        prev1_next     = prev1;
        prev2_next     = prev2;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next     = RUN;
                    rd_addr_next   = '0;
                    busy_next      = 1'b1;
                    pass_next      = 1'b0;
                    fail_idx_next  = '0;
                    err_count_next = '0;
                    fail_seen_next = 1'b0;
                end
            end
            RUN: begin
                if (mismatch) begin
                    err_count_next = err_count + ERR_W'(1);
                    if (!fail_seen) begin
                        fail_idx_next  = rd_addr;
                        fail_seen_next = 1'b1;
                    end
                end
                prev2_next = prev1;
                prev1_next = bus.rd_data;
                if (rd_addr == LAST_IDX) begin
                    state_next   = IDLE;
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                    pass_next    = (err_count == '0) && !mismatch;
                    rd_addr_next = '0;
                end else begin
                    rd_addr_next = rd_addr + AW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_idx  <= '0;
            err_count <= '0;
            fail_seen <= 1'b0;
            prev1     <= '0;
            prev2     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values regardless of statement order.
            state     <= state_next;
            rd_addr   <= rd_addr_next;
            busy      <= busy_next;
            done      <= done_next;
            pass      <= pass_next;
            fail_idx  <= fail_idx_next;
            err_count <= err_count_next;
            fail_seen <= fail_seen_next;
            prev1     <= prev1_next;
            prev2     <= prev2_next;
        end
    end
endmodule

// File: tb/tb_fib_regfile_checker.sv
// Directed bench for fib_regfile_checker: one instance with seed checking,
// one without, both reading the same modelled register file.
module tb_fib_regfile_checker;
    logic clk = 1'b0;
    logic reset;
    logic [15:0] mem [16];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fib_regfile_checker_if #(.WIDTH(16), .NUM_REGS(16)) if_s ();
    fib_regfile_checker_if #(.WIDTH(16), .NUM_REGS(16)) if_n ();

    assign if_s.rd_data = mem[if_s.rd_addr];
    assign if_n.rd_data = mem[if_n.rd_addr];

    fib_regfile_checker #(.WIDTH(16), .NUM_REGS(16), .CHECK_SEEDS(1), .SEED0(1), .SEED1(1))
        dut_s (.clk(clk), .reset(reset), .bus(if_s));
    fib_regfile_checker #(.WIDTH(16), .NUM_REGS(16), .CHECK_SEEDS(0), .SEED0(1), .SEED1(1))
        dut_n (.clk(clk), .reset(reset), .bus(if_n));

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fib();
        int fib [16] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987};
        for (int i = 0; i < 16; i++) mem[i] = 16'(fib[i]);
    endtask

    task automatic load_mod();
        int vals [16] = '{'hFFFF, 1, 0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
        for (int i = 0; i < 16; i++) mem[i] = 16'(vals[i]);
    endtask

    // Full pass on the seed-checking instance: busy and address sequence, done at start+17.
    task automatic run_pass(input string tag, input int exp_pass, input int exp_idx, input int exp_err);
        if_s.start = 1'b1;
        tick();
        if_s.start = 1'b0;
        check({tag, ".busy0"}, if_s.busy, 1);
        check({tag, ".addr0"}, if_s.rd_addr, 0);
        for (int i = 1; i < 16; i++) begin
            tick();
            check({tag, ".addr"}, if_s.rd_addr, i);
            check({tag, ".done_early"}, if_s.done, 0);
        end
        tick();
        check({tag, ".done"}, if_s.done, 1);
        check({tag, ".busy_end"}, if_s.busy, 0);
        check({tag, ".pass"}, if_s.pass, exp_pass);
        check({tag, ".fail_idx"}, if_s.fail_idx, exp_idx);
        check({tag, ".err_count"}, if_s.err_count, exp_err);
        tick();
        check({tag, ".done_clr"}, if_s.done, 0);
    endtask

    initial begin
        reset = 1'b1;
        if_s.start = 1'b0;
        if_n.start = 1'b0;
        load_fib();
        tick();
        tick();
        check("rst.busy", if_s.busy, 0);
        check("rst.done", if_s.done, 0);
        check("rst.pass", if_s.pass, 0);
        check("rst.rd_addr", if_s.rd_addr, 0);
        check("rst.fail_idx", if_s.fail_idx, 0);
        check("rst.err_count", if_s.err_count, 0);
        reset = 1'b0;
        tick();

        run_pass("good", 1, 0, 0);

        mem[7] = 16'd22;
        run_pass("r7bad", 0, 7, 3);
        mem[7] = 16'd21;

        // Modular Fibonacci with a wrapping sum: accepted without seed checks.
        load_mod();
        if_n.start = 1'b1;
        tick();
        if_n.start = 1'b0;
        check("mod_n.busy", if_n.busy, 1);
        repeat (15) tick();
        check("mod_n.done_early", if_n.done, 0);
        tick();
        check("mod_n.done", if_n.done, 1);
        check("mod_n.pass", if_n.pass, 1);
        check("mod_n.err_count", if_n.err_count, 0);
        check("mod_n.fail_idx", if_n.fail_idx, 0);
        tick();
        run_pass("mod_s", 0, 0, 1);

        // start during RUN is ignored; start in the done cycle begins a new pass.
        load_fib();
        if_s.start = 1'b1;
        tick();
        if_s.start = 1'b0;
        repeat (5) tick();
        check("ign.addr5", if_s.rd_addr, 5);
        if_s.start = 1'b1;
        tick();
        if_s.start = 1'b0;
        check("ign.addr6", if_s.rd_addr, 6);
        check("ign.busy6", if_s.busy, 1);
        tick();
        check("ign.addr7", if_s.rd_addr, 7);
        repeat (8) tick();
        check("ign.addr15", if_s.rd_addr, 15);
        check("ign.done_early", if_s.done, 0);
        tick();
        check("ign.done", if_s.done, 1);
        check("ign.pass", if_s.pass, 1);
        if_s.start = 1'b1;
        tick();
        if_s.start = 1'b0;
        check("b2b.done_clr", if_s.done, 0);
        check("b2b.busy", if_s.busy, 1);
        check("b2b.pass_clr", if_s.pass, 0);
        check("b2b.addr0", if_s.rd_addr, 0);
        repeat (15) tick();
        tick();
        check("b2b.done", if_s.done, 1);
        check("b2b.pass", if_s.pass, 1);
        tick();

        // Reset mid-RUN after a mismatch has already been recorded.
        mem[7] = 16'd22;
        if_s.start = 1'b1;
        tick();
        if_s.start = 1'b0;
        repeat (8) tick();
        check("mid.addr8", if_s.rd_addr, 8);
        check("mid.err_pre", if_s.err_count, 1);
        check("mid.idx_pre", if_s.fail_idx, 7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid.busy", if_s.busy, 0);
        check("mid.done", if_s.done, 0);
        check("mid.pass", if_s.pass, 0);
        check("mid.rd_addr", if_s.rd_addr, 0);
        check("mid.err_count", if_s.err_count, 0);
        check("mid.fail_idx", if_s.fail_idx, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("mid.no_done", if_s.done, 0);
            check("mid.idle", if_s.busy, 0);
        end
        mem[7] = 16'd21;
        run_pass("after_rst", 1, 0, 0);

        for (int i = 0; i < 16; i++) mem[i] = 16'd0;
        run_pass("zeros", 0, 0, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
